// File: rtl/inst_queue_nway_pkg.sv
// Shared instruction-queue types, default sizing and the modular pointer adder
// used by the queue, ROB and OBQ.
package inst_queue_nway_pkg;

    localparam int IQ_DEPTH     = 16;
    localparam int IQ_IN_WIDTH  = 2;
    localparam int IQ_OUT_WIDTH = 2;

    localparam logic [31:0] NOOP_IR = 32'h0000_0013;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } BRANCH_INST;

    typedef struct packed {
        logic        valid_inst;
        logic [31:0] ir;
        logic [31:0] npc;
        BRANCH_INST  branch_inst;
    } INST_Q;

    localparam INST_Q NOOP_INST = '{valid_inst: 1'b0, ir: NOOP_IR, npc: 32'h0, branch_inst: '0};

    // Conditional subtract keeps non-power-of-two depths correct; inc must not exceed depth.
    function automatic logic [31:0] ptr_add(input logic [31:0] ptr, input logic [31:0] inc,
                                            input logic [31:0] depth);
        logic [31:0] sum;
        sum = ptr + inc;
        if (sum >= depth) sum = sum - depth;
        return sum;
    endfunction

endpackage

// File: rtl/inst_queue_nway_ptr_ctrl.sv
// Head/tail pointers, occupancy/free counters and the registered full flag
// for the N-wide instruction queue.
module iq_ptr_ctrl
    import inst_queue_nway_pkg::*;
#(
    parameter int DEPTH     = IQ_DEPTH,
    parameter int IN_WIDTH  = IQ_IN_WIDTH,
    parameter int OUT_WIDTH = IQ_OUT_WIDTH,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1),
    localparam int PUSH_W   = $clog2(IN_WIDTH + 1),
    localparam int POP_W    = $clog2(OUT_WIDTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [PUSH_W-1:0] i_pushes,
    input  logic [POP_W-1:0]  i_pops,
    input  logic              i_flush,
    output logic [PTR_W-1:0]  o_head,
    output logic [PTR_W-1:0]  o_tail,
    output logic [CNT_W-1:0]  o_occ,
    output logic [CNT_W-1:0]  o_free,
    output logic              o_full
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_occ;
    logic [CNT_W-1:0] r_free;
    logic             r_full;
    logic [CNT_W-1:0] w_occ_next;
    logic [CNT_W-1:0] w_free_next;

    always_comb begin
        w_occ_next  = r_occ + CNT_W'(i_pushes) - CNT_W'(i_pops);
        w_free_next = CNT_W'(DEPTH) - w_occ_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_free <= CNT_W'(DEPTH);
            r_full <= 1'b0;
        end else if (i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
            r_free <= CNT_W'(DEPTH);
            r_full <= 1'b0;
        end else begin
            r_head <= PTR_W'(ptr_add(32'(r_head), 32'(i_pops), 32'(DEPTH)));
            r_tail <= PTR_W'(ptr_add(32'(r_tail), 32'(i_pushes), 32'(DEPTH)));
            r_occ  <= w_occ_next;
            r_free <= w_free_next;
            r_full <= (w_free_next < CNT_W'(IN_WIDTH));
        end
    end

    assign o_head = r_head;
    assign o_tail = r_tail;
    assign o_occ  = r_occ;
    assign o_free = r_free;
    assign o_full = r_full;

endmodule

// File: rtl/inst_queue_nway.sv
// N-wide circular instruction queue between fetch2 and decode/dispatch:
// entry storage, write lanes and in-order output muxing.
module inst_queue_nway
    import inst_queue_nway_pkg::*;
#(
    parameter int DEPTH              = IQ_DEPTH,
    parameter int IN_WIDTH           = IQ_IN_WIDTH,
    parameter int OUT_WIDTH          = IQ_OUT_WIDTH,
    parameter bit ASSERT_FETCH_STALL = 1'b1,
    localparam int CNT_W             = $clog2(DEPTH + 1),
    localparam int TAKE_W            = $clog2(OUT_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   fetch_valid,
    input  INST_Q [IN_WIDTH-1:0]  fetch_inst,
    input  logic [TAKE_W-1:0]     dispatch_take,
    input  logic                  branch_incorrect,
    output logic [OUT_WIDTH-1:0]  out_valid,
    output INST_Q [OUT_WIDTH-1:0] out_inst,
    output logic                  inst_queue_full,
    output logic [CNT_W-1:0]      free_count,
    output logic [CNT_W-1:0]      occ_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int PUSH_W = $clog2(IN_WIDTH + 1);

    INST_Q             r_entries [DEPTH];
    logic [PUSH_W-1:0] w_pushes;
    logic [TAKE_W-1:0] w_pops;
    logic [PTR_W-1:0]  w_head;
    logic [PTR_W-1:0]  w_tail;
    logic [PTR_W-1:0]  w_wr_idx [IN_WIDTH];
    logic [PTR_W-1:0]  w_rd_idx [OUT_WIDTH];

    // Full comes from the registered counter only, so pops never credit pushes.
    always_comb begin
        w_pushes = '0;
        if (!inst_queue_full && !branch_incorrect) begin
            for (int j = 0; j < IN_WIDTH; j++) w_pushes = w_pushes + PUSH_W'(fetch_valid[j]);
        end
        w_pops = dispatch_take;
        if (branch_incorrect) w_pops = '0;
        else if (CNT_W'(dispatch_take) > occ_count) w_pops = TAKE_W'(occ_count);
    end

    always_comb begin
        for (int j = 0; j < IN_WIDTH; j++)
            w_wr_idx[j] = PTR_W'(ptr_add(32'(w_tail), 32'(j), 32'(DEPTH)));
        for (int i = 0; i < OUT_WIDTH; i++)
            w_rd_idx[i] = PTR_W'(ptr_add(32'(w_head), 32'(i), 32'(DEPTH)));
    end

    iq_ptr_ctrl #(
        .DEPTH     (DEPTH),
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_ptr_ctrl (
        .clock    (clock),
        .reset    (reset),
        .i_pushes (w_pushes),
        .i_pops   (w_pops),
        .i_flush  (branch_incorrect),
        .o_head   (w_head),
        .o_tail   (w_tail),
        .o_occ    (occ_count),
        .o_free   (free_count),
        .o_full   (inst_queue_full)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) r_entries[e] <= NOOP_INST;
        end else if (branch_incorrect) begin
            for (int e = 0; e < DEPTH; e++) r_entries[e].valid_inst <= 1'b0;
        end else begin
            for (int j = 0; j < IN_WIDTH; j++) begin
                if (PUSH_W'(j) < w_pushes) begin
                    r_entries[w_wr_idx[j]]            <= fetch_inst[j];
                    r_entries[w_wr_idx[j]].valid_inst <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        out_valid = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            out_inst[i]  = NOOP_INST;
            out_valid[i] = (occ_count > CNT_W'(i));
            if (out_valid[i]) out_inst[i] = r_entries[w_rd_idx[i]];
        end
    end

    a_take_le_occ: assert property (@(posedge clock) disable iff (reset)
        branch_incorrect || (CNT_W'(dispatch_take) <= occ_count))
        else $error("dispatch_take exceeds occupancy");

    a_fetch_thermo: assert property (@(posedge clock) disable iff (reset)
        (fetch_valid & (fetch_valid + IN_WIDTH'(1))) == '0)
        else $error("fetch_valid is not thermometer coded");

    if (ASSERT_FETCH_STALL) begin : g_stall_chk
        a_fetch_stall: assert property (@(posedge clock) disable iff (reset)
            !(inst_queue_full && (|fetch_valid) && !branch_incorrect))
            else $error("fetch_valid asserted while inst_queue_full");
    end

endmodule

// File: tb/tb_inst_queue_nway.sv
// Directed-vector bench for inst_queue_nway: a 16-deep instance for fill, stall,
// flush and async reset, and a 5-deep instance for non-power-of-two wrap.
module tb_inst_queue_nway;
    import inst_queue_nway_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [1:0]  a_fv, a_take, a_ov, b_fv, b_take, b_ov;
    logic        a_br, a_full, b_br, b_full;
    INST_Q [1:0] a_fi, a_oi, b_fi, b_oi;
    logic [4:0]  a_free, a_occ;
    logic [2:0]  b_free, b_occ;

    inst_queue_nway #(.DEPTH(16), .IN_WIDTH(2), .OUT_WIDTH(2), .ASSERT_FETCH_STALL(1'b0)) u_q16 (
        .clock(clock), .reset(reset), .fetch_valid(a_fv), .fetch_inst(a_fi),
        .dispatch_take(a_take), .branch_incorrect(a_br), .out_valid(a_ov), .out_inst(a_oi),
        .inst_queue_full(a_full), .free_count(a_free), .occ_count(a_occ));

    inst_queue_nway #(.DEPTH(5), .IN_WIDTH(2), .OUT_WIDTH(2)) u_q5 (
        .clock(clock), .reset(reset), .fetch_valid(b_fv), .fetch_inst(b_fi),
        .dispatch_take(b_take), .branch_incorrect(b_br), .out_valid(b_ov), .out_inst(b_oi),
        .inst_queue_full(b_full), .free_count(b_free), .occ_count(b_occ));

    // Expected lane contents are instruction tags; -1 means an invalid (NOOP) lane.
    typedef struct {
        int         which;
        logic [1:0] vld;
        int         ir0;
        int         ir1;
        int         occ;
        int         free;
        logic       full;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    event ev_check;

    function automatic logic [31:0] irk(input int k);
        return 32'(32'h1000 + k);
    endfunction

    function automatic logic [31:0] exp_ir(input int k);
        return (k < 0) ? NOOP_IR : irk(k);
    endfunction

    function automatic INST_Q mk(input int k);
        INST_Q q;
        q            = '0;
        q.valid_inst = 1'b1;
        q.ir         = irk(k);
        q.npc        = 32'(k * 4);
        return q;
    endfunction

    task automatic cmp(input string nm, input string f, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, f, act, req);
        end
    endtask

    // Monitor: checks the oldest pending expectation on each falling edge,
    // or immediately when the stimulus signals an asynchronous event.
    initial begin : monitor
        exp_t        e;
        logic [1:0]  ov;
        logic [31:0] i0, i1;
        logic        v0, fl;
        int          oc, fr;
        forever begin
            @(negedge clock or ev_check);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.which == 0) begin
                    ov = a_ov; i0 = a_oi[0].ir; i1 = a_oi[1].ir; v0 = a_oi[0].valid_inst;
                    oc = int'(a_occ); fr = int'(a_free); fl = a_full;
                end else begin
                    ov = b_ov; i0 = b_oi[0].ir; i1 = b_oi[1].ir; v0 = b_oi[0].valid_inst;
                    oc = int'(b_occ); fr = int'(b_free); fl = b_full;
                end
                cmp(e.nm, "out_valid", longint'(ov), longint'(e.vld));
                cmp(e.nm, "ir0", longint'(i0), longint'(exp_ir(e.ir0)));
                cmp(e.nm, "ir1", longint'(i1), longint'(exp_ir(e.ir1)));
                cmp(e.nm, "valid_inst0", longint'(v0), longint'(e.vld[0]));
                cmp(e.nm, "occ", longint'(oc), longint'(e.occ));
                cmp(e.nm, "free", longint'(fr), longint'(e.free));
                cmp(e.nm, "full", longint'(fl), longint'(e.full));
            end
        end
    end

    task automatic idle_inputs();
        a_fv = '0; a_take = '0; a_br = 1'b0; a_fi[0] = '0; a_fi[1] = '0;
        b_fv = '0; b_take = '0; b_br = 1'b0; b_fi[0] = '0; b_fi[1] = '0;
    endtask

    task automatic step(input int w, input logic [1:0] fv, input int k0, input int k1,
                        input logic [1:0] take, input logic br, input logic [1:0] ev,
                        input int e0, input int e1, input int eo, input int ef,
                        input logic efl, input string nm);
        exp_t e;
        if (w == 0) begin
            a_fv = fv; a_fi[0] = mk(k0); a_fi[1] = mk(k1); a_take = take; a_br = br;
        end else begin
            b_fv = fv; b_fi[0] = mk(k0); b_fi[1] = mk(k1); b_take = take; b_br = br;
        end
        @(posedge clock);
        e.which = w; e.vld = ev; e.ir0 = e0; e.ir1 = e1;
        e.occ = eo; e.free = ef; e.full = efl; e.nm = nm;
        sb.push_back(e);
        #1;
        idle_inputs();
    endtask

    initial begin : stimulus
        exp_t e;
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        for (int n = 0; n < 3; n++) step(0, 2'b00, 0, 0, 2'd0, 1'b0, 2'b00, -1, -1, 0, 16, 1'b0, "idle");

        for (int n = 1; n <= 7; n++)
            step(0, 2'b11, 2*(n-1), 2*(n-1)+1, 2'd0, 1'b0, 2'b11, 0, 1, 2*n, 16-2*n, 1'b0, "fill");
        step(0, 2'b11, 14, 15, 2'd0, 1'b0, 2'b11, 0, 1, 16, 0, 1'b1, "fill8");
        step(0, 2'b11, 16, 17, 2'd0, 1'b0, 2'b11, 0, 1, 16, 0, 1'b1, "full_ignore");
        step(0, 2'b11, 16, 17, 2'd2, 1'b0, 2'b11, 2, 3, 14, 2, 1'b0, "pop_no_credit");
        step(0, 2'b11, 16, 17, 2'd0, 1'b0, 2'b11, 2, 3, 16, 0, 1'b1, "push_after");

        for (int n = 1; n <= 5; n++)
            step(0, 2'b00, 0, 0, 2'd2, 1'b0, 2'b11, 2+2*n, 3+2*n, 16-2*n, 2*n, 1'b0, "drain");
        step(0, 2'b11, 18, 19, 2'd2, 1'b1, 2'b00, -1, -1, 0, 16, 1'b0, "flush");
        step(0, 2'b00, 0, 0, 2'd0, 1'b0, 2'b00, -1, -1, 0, 16, 1'b0, "post_flush");

        step(1, 2'b11, 100, 101, 2'd0, 1'b0, 2'b11, 100, 101, 2, 3, 1'b0, "w5_fill");
        for (int m = 1; m <= 6; m++)
            step(1, 2'b11, 100+2*m, 101+2*m, 2'd2, 1'b0, 2'b11, 100+2*m, 101+2*m, 2, 3, 1'b0, "w5_wrap");
        step(1, 2'b00, 0, 0, 2'd2, 1'b0, 2'b00, -1, -1, 0, 5, 1'b0, "w5_drain");

        step(0, 2'b01, 20, 0, 2'd0, 1'b0, 2'b01, 20, -1, 1, 15, 1'b0, "one");
        step(0, 2'b01, 21, 0, 2'd1, 1'b0, 2'b01, 21, -1, 1, 15, 1'b0, "pop_push");

        // Mid-cycle, after the falling-edge check and well before the next rising edge.
        #6;
        reset = 1'b1;
        e.which = 0; e.vld = 2'b00; e.ir0 = -1; e.ir1 = -1;
        e.occ = 0; e.free = 16; e.full = 1'b0; e.nm = "async_reset";
        sb.push_back(e);
        #1 -> ev_check;
        #10 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/inst_queue_nway.md
Name: inst_queue_nway

Overview:
- Parametrised N-wide successor of the single-issue instruction queue.
- Circular buffer between fetch/branch-predict (fetch2) and decode/dispatch.
- Accepts up to IN_WIDTH instructions per cycle and presents up to OUT_WIDTH oldest instructions in program order.
- Downstream consumes a variable count (0..OUT_WIDTH) per cycle; the whole queue flushes on branch mispredict.

Parameters:
DEPTH, 16, number of entries; any integer >= IN_WIDTH+OUT_WIDTH, power of two not required
IN_WIDTH, 2, max instructions written per cycle
OUT_WIDTH, 2, max instructions presented/popped per cycle
CNT_W, $clog2(DEPTH+1), width of occupancy/free counters (derived, not overridden)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
fetch_valid  in  IN_WIDTH  per-lane valid; must be thermometer (lane i valid implies lanes <i valid)
fetch_inst  in  IN_WIDTH x INST_Q  fetched instructions; lane 0 oldest
dispatch_take  in  $clog2(OUT_WIDTH+1)  number of presented instructions consumed this cycle
branch_incorrect  in  1  mispredict flush
out_valid  out  OUT_WIDTH  lane i holds a valid instruction
out_inst  out  OUT_WIDTH x INST_Q  oldest instructions, lane 0 = head
inst_queue_full  out  1  registered; high when free slots < IN_WIDTH (fetch must stall)
free_count  out  CNT_W  registered number of empty entries
occ_count  out  CNT_W  registered number of occupied entries

Behaviour:
- Reset is asynchronous, active-high; clock and reset are the only clock/reset ports. All state updates on rising clock edge otherwise.
- Reset state: head=0, tail=0, occ_count=0, free_count=DEPTH, inst_queue_full=0, out_valid=0.
- Reset state of every entry: valid_inst=0, ir=NOOP_INST, npc=0, branch_inst fields=0.
- Reset asserted mid-operation discards all contents immediately.
- Output path: combinational from registered state, zero latency.
  - out_inst[i] = entry[(head+i) mod DEPTH].
  - out_valid[i] = (occ_count > i).
  - Invalid lanes drive NOOP_INST with valid_inst=0.
- Pop: pops = dispatch_take. The environment guarantees dispatch_take <= popcount(out_valid); a violation is flagged by an assertion and the RTL saturates pops at occ_count.
- Push rule: pushes = popcount(fetch_valid) when inst_queue_full==0, else 0.
  - Fetch is ignored while full (assertion flags the attempt).
  - Full is evaluated from registered free_count only; same-cycle pops give no credit to pushes, which keeps the fetch_stall path short.
- Writes: lane j written to entry[(tail+j) mod DEPTH] with valid_inst=1.
- Simultaneous push and pop: both take effect the same edge.
  - occ_next = occ + pushes - pops; free_next = DEPTH - occ_next.
  - Never overflows: pushes only when free >= IN_WIDTH.
- Pointer update: head_next = (head+pops) mod DEPTH; tail_next = (tail+pushes) mod DEPTH.
  - Wrap is done by conditional subtract of DEPTH, not bit truncation, so non-power-of-two DEPTH works.
- Full/empty are distinguished by occ_count, never by head==tail.
- inst_queue_full_next = (free_next < IN_WIDTH).
- Flush (branch_incorrect=1): takes priority over push and pop in the same cycle.
  - Next edge: head=tail=0, occ=0, free=DEPTH, all entry valid_inst cleared.
  - Same-cycle fetch_valid and dispatch_take are discarded.
  - out_valid is 0 from the cycle after the flush.
- Ordering: program order is preserved across wrap; lane 0 of out is always the oldest.
- No state machine; control is a counter/pointer datapath. Throughput is IN_WIDTH in and OUT_WIDTH out per cycle sustained.

Decomposition:
- sys_defs.vh / shared package holds:
  - INST_Q and BRANCH_INST typedefs and NOOP_INST.
  - IQ_DEPTH, IQ_IN_WIDTH, IQ_OUT_WIDTH defaults.
  - A ptr_add(ptr, inc, DEPTH) modular-add function, shared with ROB and OBQ.
- One natural sub-module: iq_ptr_ctrl, holding the head/tail/occ/free registers and the full flag. Its inputs are pushes, pops and flush.
- inst_queue_nway itself holds the entry array, the write lanes and the output muxing.

Test Plan:
- Reset then idle 3 cycles -> out_valid=00, occ=0, free=16, full=0.
- Push A,B (fetch_valid=11) each cycle for 7 cycles, take=0 -> occ=14, free=2, full=0.
  - Push C,D (8th push) -> occ=16, full=1.
  - Further pushes ignored; occ stays 16.
- Full queue, take=2 with fetch_valid=11 -> pops 2, pushes 0 (no credit); occ=14, full=0.
  - Next cycle the push succeeds.
- Wrap with DEPTH=5, IN=OUT=2: push 2, take 2, repeated 6 cycles -> head and tail wrap 0→2→4→1→3→0.
  - out_inst order always matches push order; occ never exceeds 2.
- Queue holds 6 entries, branch_incorrect=1 together with fetch_valid=11 and take=2 -> next cycle occ=0, out_valid=00, head=tail=0; nothing pushed.
- Occupancy 1, take=1 with fetch_valid=01 (X) -> out_valid=01 with out_inst[0]=X next cycle, occ=1.
  - Assert reset asynchronously mid-cycle -> out_valid=00 immediately, without waiting for a clock edge.
